// File: rtl/div_unit_pkg.sv
// ============================================================================
//  Module  : div_unit_pkg
//  Purpose : Shared constants for the multi-cycle DIV/DIVU unit: datapath
//            widths, FSM state encodings, handshake levels and reset level.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

  // Datapath widths
  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  // Divider FSM state encodings
  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  // Request levels on start_i
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  // Levels on ready_o
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Misc
  localparam logic [RegBus-1:0] ZeroWord  = '0;
  localparam logic              RstEnable = 1'b1;

endpackage : div_unit_pkg

`default_nettype wire

// File: rtl/div_unit_if.sv
// ============================================================================
//  Module  : div_unit_if
//  Purpose : Request/result bundle between the execute stage and div_unit.
//  Ports   : signed_div_i  1 = signed DIV, 0 = DIVU
//            opdata1_i     dividend
//            opdata2_i     divisor
//            start_i       request, held until the result is consumed
//            annul_i       cancel (flush / exception)
//            result_o      {remainder, quotient}
//            ready_o       result_o valid
//            modport master: execute stage side; modport slave: divider side
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int DATA_W = RegBus
);

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface : div_unit_if

`default_nettype wire

// File: rtl/div_unit_step.sv
// ============================================================================
//  Module  : div_step
//  Purpose : One restoring-division iteration, purely combinational.
//            Trial-subtracts the divisor from the upper part of the working
//            register and shifts the resulting quotient bit in at the bottom.
//  Ports   : work_i     [2*DATA_W:0]  current working register
//            divisor_i  [DATA_W-1:0]  divisor magnitude
//            work_o     [2*DATA_W:0]  working register after this step
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
  import div_unit_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic [2*DATA_W:0]  work_i,
  input  logic [DATA_W-1:0]  divisor_i,
  output logic [2*DATA_W:0]  work_o
);

  logic [DATA_W:0] diff;

  always_comb begin
    diff = work_i[2*DATA_W:DATA_W] - {1'b0, divisor_i};
    // The partial remainder is always below twice the divisor, so a set MSB
    // on the difference means the trial subtract borrowed.
    if (diff[DATA_W]) begin
      work_o = {work_i[2*DATA_W-1:0], 1'b0};
    end else begin
      work_o = {diff[DATA_W-1:0], work_i[DATA_W-1:0], 1'b1};
    end
  end

endmodule : div_step

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  Module  : div_unit
//  Purpose : Multi-cycle DIV/DIVU unit, one quotient bit per clock.
//            Quotient is returned in the low half of result_o (LO), the
//            remainder in the high half (HI). Divide-by-zero returns 0.
//  Ports   : clk   clock
//            rst   synchronous active-high reset
//            bus   div_unit_if.slave (operands, start/annul in;
//                  result_o/ready_o out, both registered)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic            clk,
  input  logic            rst,
  div_unit_if.slave       bus
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);

  logic [1:0]            state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [2*DATA_W:0]     work_q,     work_d;
  logic [DATA_W-1:0]     divisor_q,  divisor_d;
  logic                  signed_q,   signed_d;
  logic                  op1_msb_q,  op1_msb_d;
  logic                  op2_msb_q,  op2_msb_d;
  logic [2*DATA_W-1:0]   result_q,   result_d;
  logic                  ready_q,    ready_d;

  logic [2*DATA_W:0]     step_work;
  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W-1:0]     quot_raw, rem_raw, quot_fix, rem_fix;

  div_step #(.DATA_W(DATA_W)) u_div_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_work)
  );

  // Magnitudes: only a signed request with a negative operand is negated.
  assign op1_abs = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i
                                                                 : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i
                                                                 : bus.opdata2_i;

  // After the last step the remainder sits above bit DATA_W and the quotient
  // fills the low word; bit DATA_W is a leftover shift slot.
  assign quot_raw = work_q[DATA_W-1:0];
  assign rem_raw  = work_q[2*DATA_W:DATA_W+1];
  assign quot_fix = (signed_q && (op1_msb_q ^ op2_msb_q)) ? -quot_raw : quot_raw;
  assign rem_fix  = (signed_q && op1_msb_q)               ? -rem_raw  : rem_raw;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    op1_msb_d = op1_msb_q;
    op2_msb_d = op2_msb_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            // Dividend is pre-shifted by one so the first trial subtract
            // already sees its MSB; DATA_W steps then consume every bit.
            work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
            divisor_d = op2_abs;
            signed_d  = bus.signed_div_i;
            op1_msb_d = bus.opdata1_i[DATA_W-1];
            op2_msb_d = bus.opdata2_i[DATA_W-1];
          end
        end
      end

      DivByZero: begin
        if (bus.annul_i) begin
          state_d = DivFree;
          cnt_d   = '0;
        end else begin
          work_d  = '0;
          state_d = DivEnd;
        end
      end

      DivOn: begin
        if (bus.annul_i) begin
          state_d = DivFree;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Corrected values also go back into work so END re-presents them.
          work_d   = {rem_fix, work_q[DATA_W], quot_fix};
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      DivEnd: begin
        if (bus.annul_i || bus.start_i == DivStop) begin
          state_d  = DivFree;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else begin
          result_d = {work_q[2*DATA_W:DATA_W+1], work_q[DATA_W-1:0]};
          ready_d  = DivResultReady;
        end
      end

      default: begin
        state_d  = DivFree;
        cnt_d    = '0;
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase

    // A cancel anywhere outside IDLE drops the result in the same edge.
    if (bus.annul_i && state_q != DivFree) begin
      result_d = '0;
      ready_d  = DivResultNotReady;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      op1_msb_q <= 1'b0;
      op2_msb_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      op1_msb_q <= op1_msb_d;
      op2_msb_q <= op2_msb_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule : div_unit

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module  : tb_div_unit
//  Purpose : Self-checking bench for div_unit: directed vector table,
//            annul / reset / END-cancel sequences and random operations
//            checked against an arithmetic reference model.
//  Ports   : none (top-level bench)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(W)) bus ();

  div_unit #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer division (truncating toward zero,
  // remainder takes the dividend's sign); zero divisor yields 0.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: start held, measure latency from the sampling edge,
  // scramble operands mid-flight, check hold in END, drop start, check clear.
  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat_exp);
    int lat;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    tick();                                   // E0
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~sgn;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (bus.ready_o) lat = k;
    end
    check({name, " latency"}, 64'(lat), 64'(lat_exp));
    check({name, " result"}, bus.result_o, exp);
    tick();
    check({name, " hold"}, {bus.result_o[62:0], bus.ready_o}, {exp[62:0], 1'b1});
    @(negedge clk);
    bus.start_i = 1'b0;
    tick();
    check({name, " clear"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic sgn;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'h00000001, 64'h00000000_FFFFFFFF, 33};
    vecs[5] = '{1'b1, 32'h12345678,   32'h00000000, 64'h00000000_00000000, 2};
    vecs[6] = '{1'b0, 32'd5,          32'd9,        64'h00000005_00000000, 33};
    vecs[7] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33};

    // Reset while a request is presented: reset must win.
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd50;
    bus.opdata2_i    = 32'd5;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    check("reset state", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    tick();
    check("idle after reset", {bus.result_o[62:0], bus.ready_o}, 64'd0);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat);
    end

    // Annul sampled at E11, new 9/3 request sampled at E13.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    tick();                                   // E0
    for (int k = 1; k <= 10; k++) tick();     // E10
    @(negedge clk);
    bus.annul_i = 1'b1;
    tick();                                   // E11
    check("annul clears", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    tick();                                   // E12
    @(negedge clk);
    bus.annul_i   = 1'b0;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    tick();                                   // E13 samples the new request
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (bus.ready_o) lat = k;
    end
    check("after annul latency", 64'(lat), 64'd33);
    check("after annul result", bus.result_o, 64'h00000000_00000003);
    // Annul while in END with start still high.
    @(negedge clk);
    bus.annul_i = 1'b1;
    tick();
    check("annul in END", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd10;
    bus.start_i   = 1'b1;
    tick();                                   // E0
    for (int k = 1; k <= 19; k++) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();                                   // E20
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    tick();                                   // E21
    check("mid-op reset", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.ready_o) lat = k;
    end
    check("no result after reset", 64'(lat), 64'd0);
    run_op("post-reset op", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = sgn ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), sgn, a, b, ref_div(sgn, a, b),
             (b == 32'd0) ? 2 : 33);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_unit

`default_nettype wire
